axi4_lite_arb2: RTL and testbench

Two-manager to one-subordinate AXI4-Lite arbiter. It lets two requesters, for example the VIP manager and a future on-chip CPU or DMA port, share one axi4_lite_sub register block.
- Write channels (AW/W/B) and read channels (AR/R) are arbitrated independently, each by its own round-robin FSM.
- At most one write and one read are outstanding toward the subordinate at any time.
- There is no address decoding. All accepted transactions pass through to m_axi unchanged.

---
 rtl/axi4_lite_arb2_if.sv | 38 +++
 rtl/axi4_lite_arb2.sv | 178 +++++++++++++++++
 tb/tb_axi4_lite_arb2.sv | 397 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_arb2_if.sv
// AXI4-Lite bundle shared by both arbiter manager ports and the subordinate port.
// Payload widths follow DATA_WIDTH/ADDR_WIDTH; wstrb covers one bit per data byte.
interface axi4_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                      awvalid;
    logic                      awready;
    logic [ADDR_WIDTH-1:0]     awaddr;
    logic [2:0]                awprot;
    logic                      wvalid;
    logic                      wready;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH/8-1:0]   wstrb;
    logic                      bvalid;
    logic                      bready;
    logic [1:0]                bresp;
    logic                      arvalid;
    logic                      arready;
    logic [ADDR_WIDTH-1:0]     araddr;
    logic [2:0]                arprot;
    logic                      rvalid;
    logic                      rready;
    logic [DATA_WIDTH-1:0]     rdata;
    logic [1:0]                rresp;

    modport manager (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport subordinate (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi4_lite_arb2.sv
// Two-manager to one-subordinate AXI4-Lite arbiter with independent round-robin
// write (AW/W/B) and read (AR/R) FSMs, one transaction outstanding per direction.
module axi4_lite_arb2 #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic             aclk,
    input  logic             aresetn,
    axi4_if.subordinate      s0_axi,
    axi4_if.subordinate      s1_axi,
    axi4_if.manager          m_axi,
    output logic             wr_busy,
    output logic             rd_busy,
    output logic             wr_owner,
    output logic             rd_owner
);

    typedef enum logic [1:0] {W_IDLE, W_FWD, W_RESP} wr_state_e;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_e;

    wr_state_e r_wr_state, w_wr_state_nxt;
    rd_state_e r_rd_state, w_rd_state_nxt;
    logic      r_wr_owner, w_wr_owner_nxt;
    logic      r_rd_owner, w_rd_owner_nxt;
    logic      r_aw_done, w_aw_done_nxt;
    logic      r_w_done, w_w_done_nxt;

    logic w_own_awvalid, w_own_wvalid, w_own_bready;
    logic w_own_arvalid, w_own_rready;
    logic w_aw_rdy, w_w_rdy, w_b_vld, w_ar_rdy, w_r_vld;

    logic [ADDR_WIDTH-1:0] w_awaddr, w_araddr;
    logic [DATA_WIDTH-1:0] w_wdata;

    assign w_own_awvalid = r_wr_owner ? s1_axi.awvalid : s0_axi.awvalid;
    assign w_own_wvalid  = r_wr_owner ? s1_axi.wvalid  : s0_axi.wvalid;
    assign w_own_bready  = r_wr_owner ? s1_axi.bready  : s0_axi.bready;
    assign w_own_arvalid = r_rd_owner ? s1_axi.arvalid : s0_axi.arvalid;
    assign w_own_rready  = r_rd_owner ? s1_axi.rready  : s0_axi.rready;

    // Payload is muxed from the owner unconditionally; valids alone qualify it.
    assign w_awaddr      = r_wr_owner ? s1_axi.awaddr : s0_axi.awaddr;
    assign w_wdata       = r_wr_owner ? s1_axi.wdata  : s0_axi.wdata;
    assign w_araddr      = r_rd_owner ? s1_axi.araddr : s0_axi.araddr;
    assign m_axi.awaddr  = w_awaddr;
    assign m_axi.awprot  = r_wr_owner ? s1_axi.awprot : s0_axi.awprot;
    assign m_axi.wdata   = w_wdata;
    assign m_axi.wstrb   = r_wr_owner ? s1_axi.wstrb  : s0_axi.wstrb;
    assign m_axi.araddr  = w_araddr;
    assign m_axi.arprot  = r_rd_owner ? s1_axi.arprot : s0_axi.arprot;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wr_state <= W_IDLE;
            r_wr_owner <= 1'b1;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
        end else begin
            r_wr_state <= w_wr_state_nxt;
            r_wr_owner <= w_wr_owner_nxt;
            r_aw_done  <= w_aw_done_nxt;
            r_w_done   <= w_w_done_nxt;
        end
    end

    always_comb begin
        w_wr_state_nxt = r_wr_state;
        w_wr_owner_nxt = r_wr_owner;
        w_aw_done_nxt  = r_aw_done;
        w_w_done_nxt   = r_w_done;
        m_axi.awvalid  = 1'b0;
        m_axi.wvalid   = 1'b0;
        m_axi.bready   = 1'b0;
        w_aw_rdy       = 1'b0;
        w_w_rdy        = 1'b0;
        w_b_vld        = 1'b0;
        unique case (r_wr_state)
            W_IDLE: begin
                w_aw_done_nxt = 1'b0;
                w_w_done_nxt  = 1'b0;
                if (s0_axi.awvalid || s1_axi.awvalid) begin
                    w_wr_owner_nxt = (s0_axi.awvalid && s1_axi.awvalid) ? ~r_wr_owner
                                                                        : s1_axi.awvalid;
                    w_wr_state_nxt = W_FWD;
                end
            end
            W_FWD: begin
                // Valids depend only on done flags, never on m_axi readies.
                m_axi.awvalid = w_own_awvalid & ~r_aw_done;
                m_axi.wvalid  = w_own_wvalid  & ~r_w_done;
                w_aw_rdy      = m_axi.awready & ~r_aw_done;
                w_w_rdy       = m_axi.wready  & ~r_w_done;
                w_aw_done_nxt = r_aw_done | (w_own_awvalid & m_axi.awready);
                w_w_done_nxt  = r_w_done  | (w_own_wvalid  & m_axi.wready);
                if (w_aw_done_nxt && w_w_done_nxt) begin
                    w_wr_state_nxt = W_RESP;
                end
            end
            W_RESP: begin
                m_axi.bready = w_own_bready;
                w_b_vld      = m_axi.bvalid;
                if (m_axi.bvalid && w_own_bready) begin
                    w_wr_state_nxt = W_IDLE;
                    w_aw_done_nxt  = 1'b0;
                    w_w_done_nxt   = 1'b0;
                end
            end
            default: w_wr_state_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rd_state <= R_IDLE;
            r_rd_owner <= 1'b1;
        end else begin
            r_rd_state <= w_rd_state_nxt;
            r_rd_owner <= w_rd_owner_nxt;
        end
    end

    always_comb begin
        w_rd_state_nxt = r_rd_state;
        w_rd_owner_nxt = r_rd_owner;
        m_axi.arvalid  = 1'b0;
        m_axi.rready   = 1'b0;
        w_ar_rdy       = 1'b0;
        w_r_vld        = 1'b0;
        unique case (r_rd_state)
            R_IDLE: begin
                if (s0_axi.arvalid || s1_axi.arvalid) begin
                    w_rd_owner_nxt = (s0_axi.arvalid && s1_axi.arvalid) ? ~r_rd_owner
                                                                        : s1_axi.arvalid;
                    w_rd_state_nxt = R_ADDR;
                end
            end
            R_ADDR: begin
                m_axi.arvalid = w_own_arvalid;
                w_ar_rdy      = m_axi.arready;
                if (w_own_arvalid && m_axi.arready) begin
                    w_rd_state_nxt = R_DATA;
                end
            end
            R_DATA: begin
                m_axi.rready = w_own_rready;
                w_r_vld      = m_axi.rvalid;
                if (m_axi.rvalid && w_own_rready) begin
                    w_rd_state_nxt = R_IDLE;
                end
            end
            default: w_rd_state_nxt = R_IDLE;
        endcase
    end

    // Non-owner sees every ready/valid held low; response payload is broadcast.
    assign s0_axi.awready = w_aw_rdy & ~r_wr_owner;
    assign s1_axi.awready = w_aw_rdy &  r_wr_owner;
    assign s0_axi.wready  = w_w_rdy  & ~r_wr_owner;
    assign s1_axi.wready  = w_w_rdy  &  r_wr_owner;
    assign s0_axi.bvalid  = w_b_vld  & ~r_wr_owner;
    assign s1_axi.bvalid  = w_b_vld  &  r_wr_owner;
    assign s0_axi.bresp   = m_axi.bresp;
    assign s1_axi.bresp   = m_axi.bresp;
    assign s0_axi.arready = w_ar_rdy & ~r_rd_owner;
    assign s1_axi.arready = w_ar_rdy &  r_rd_owner;
    assign s0_axi.rvalid  = w_r_vld  & ~r_rd_owner;
    assign s1_axi.rvalid  = w_r_vld  &  r_rd_owner;
    assign s0_axi.rdata   = m_axi.rdata;
    assign s1_axi.rdata   = m_axi.rdata;
    assign s0_axi.rresp   = m_axi.rresp;
    assign s1_axi.rresp   = m_axi.rresp;

    assign wr_busy  = (r_wr_state != W_IDLE);
    assign rd_busy  = (r_rd_state != R_IDLE);
    assign wr_owner = r_wr_owner;
    assign rd_owner = r_rd_owner;

endmodule

// File: tb/tb_axi4_lite_arb2.sv
// Directed bench for axi4_lite_arb2: two manager drivers, a small register-file
// subordinate model (SLVERR at 0x100 and above) and negedge monitors.
module tb_axi4_lite_arb2;

    logic clk;
    logic aresetn;
    logic wr_busy, rd_busy, wr_owner, rd_owner;

    axi4_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) s0_if ();
    axi4_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) s1_if ();
    axi4_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) m_if ();

    axi4_lite_arb2 #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .aclk     (clk),
        .aresetn  (aresetn),
        .s0_axi   (s0_if),
        .s1_axi   (s1_if),
        .m_axi    (m_if),
        .wr_busy  (wr_busy),
        .rd_busy  (rd_busy),
        .wr_owner (wr_owner),
        .rd_owner (rd_owner)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Manager-side drive, indexed by manager number.
    logic        aw_v [2];
    logic        w_v  [2];
    logic        b_r  [2];
    logic        ar_v [2];
    logic        r_r  [2];
    logic [31:0] aw_a [2];
    logic [31:0] w_d  [2];
    logic [31:0] ar_a [2];

    assign s0_if.awvalid = aw_v[0];  assign s1_if.awvalid = aw_v[1];
    assign s0_if.awaddr  = aw_a[0];  assign s1_if.awaddr  = aw_a[1];
    assign s0_if.awprot  = 3'b000;   assign s1_if.awprot  = 3'b010;
    assign s0_if.wvalid  = w_v[0];   assign s1_if.wvalid  = w_v[1];
    assign s0_if.wdata   = w_d[0];   assign s1_if.wdata   = w_d[1];
    assign s0_if.wstrb   = 4'hF;     assign s1_if.wstrb   = 4'hF;
    assign s0_if.bready  = b_r[0];   assign s1_if.bready  = b_r[1];
    assign s0_if.arvalid = ar_v[0];  assign s1_if.arvalid = ar_v[1];
    assign s0_if.araddr  = ar_a[0];  assign s1_if.araddr  = ar_a[1];
    assign s0_if.arprot  = 3'b000;   assign s1_if.arprot  = 3'b010;
    assign s0_if.rready  = r_r[0];   assign s1_if.rready  = r_r[1];

    logic        s_awrdy [2];
    logic        s_wrdy  [2];
    logic        s_bvld  [2];
    logic        s_arrdy [2];
    logic        s_rvld  [2];
    logic [1:0]  s_bresp [2];
    logic [1:0]  s_rresp [2];
    logic [31:0] s_rdata [2];

    assign s_awrdy[0] = s0_if.awready;  assign s_awrdy[1] = s1_if.awready;
    assign s_wrdy[0]  = s0_if.wready;   assign s_wrdy[1]  = s1_if.wready;
    assign s_bvld[0]  = s0_if.bvalid;   assign s_bvld[1]  = s1_if.bvalid;
    assign s_arrdy[0] = s0_if.arready;  assign s_arrdy[1] = s1_if.arready;
    assign s_rvld[0]  = s0_if.rvalid;   assign s_rvld[1]  = s1_if.rvalid;
    assign s_bresp[0] = s0_if.bresp;    assign s_bresp[1] = s1_if.bresp;
    assign s_rresp[0] = s0_if.rresp;    assign s_rresp[1] = s1_if.rresp;
    assign s_rdata[0] = s0_if.rdata;    assign s_rdata[1] = s1_if.rdata;

    // Subordinate model: AW and W captured independently, write commits when both held.
    logic [31:0] mem [64];
    logic        aw_got, w_got, mdl_bvalid, mdl_rvalid;
    logic [31:0] aw_addr_q, w_data_q, mdl_rdata;
    logic [3:0]  w_strb_q;
    logic [1:0]  mdl_bresp, mdl_rresp;

    assign m_if.awready = ~aw_got & ~mdl_bvalid;
    assign m_if.wready  = ~w_got & ~mdl_bvalid;
    assign m_if.bvalid  = mdl_bvalid;
    assign m_if.bresp   = mdl_bresp;
    assign m_if.arready = ~mdl_rvalid;
    assign m_if.rvalid  = mdl_rvalid;
    assign m_if.rdata   = mdl_rdata;
    assign m_if.rresp   = mdl_rresp;

    always @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            aw_got     <= 1'b0;
            w_got      <= 1'b0;
            mdl_bvalid <= 1'b0;
            mdl_bresp  <= 2'b00;
            mdl_rvalid <= 1'b0;
            mdl_rdata  <= '0;
            mdl_rresp  <= 2'b00;
            aw_addr_q  <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
        end else begin
            if (m_if.awvalid && m_if.awready) begin
                aw_got    <= 1'b1;
                aw_addr_q <= m_if.awaddr;
            end
            if (m_if.wvalid && m_if.wready) begin
                w_got    <= 1'b1;
                w_data_q <= m_if.wdata;
                w_strb_q <= m_if.wstrb;
            end
            if (aw_got && w_got) begin
                aw_got     <= 1'b0;
                w_got      <= 1'b0;
                mdl_bvalid <= 1'b1;
                if (aw_addr_q < 32'h100) begin
                    for (int b = 0; b < 4; b++)
                        if (w_strb_q[b]) mem[aw_addr_q[7:2]][8*b +: 8] <= w_data_q[8*b +: 8];
                    mdl_bresp <= 2'b00;
                end else begin
                    mdl_bresp <= 2'b10;
                end
            end
            if (mdl_bvalid && m_if.bready) mdl_bvalid <= 1'b0;
            if (m_if.arvalid && m_if.arready) begin
                mdl_rvalid <= 1'b1;
                mdl_rdata  <= (m_if.araddr < 32'h100) ? mem[m_if.araddr[7:2]] : 32'h0;
                mdl_rresp  <= (m_if.araddr < 32'h100) ? 2'b00 : 2'b10;
            end
            if (mdl_rvalid && m_if.rready) mdl_rvalid <= 1'b0;
        end
    end

    // Monitors: handshake counts, grant order, s1 activity, channel overlap.
    int   m_aw_hs, m_w_hs, s1_aw_hs, s1_w_hs, s1_act, ovl;
    int   wr_grants[$];
    int   rd_grants[$];
    logic wr_busy_q, rd_busy_q;
    logic [2:0] last_awprot, last_arprot;

    initial begin
        m_aw_hs = 0; m_w_hs = 0; s1_aw_hs = 0; s1_w_hs = 0; s1_act = 0; ovl = 0;
        wr_busy_q = 1'b0; rd_busy_q = 1'b0; last_awprot = '0; last_arprot = '0;
    end

    always @(negedge clk) begin
        if (m_if.awvalid && m_if.awready) begin m_aw_hs++; last_awprot = m_if.awprot; end
        if (m_if.wvalid && m_if.wready) m_w_hs++;
        if (m_if.arvalid && m_if.arready) last_arprot = m_if.arprot;
        if (s1_if.awvalid && s1_if.awready) s1_aw_hs++;
        if (s1_if.wvalid && s1_if.wready) s1_w_hs++;
        if (s1_if.awready | s1_if.wready | s1_if.bvalid | s1_if.arready | s1_if.rvalid) s1_act++;
        if (wr_busy && rd_busy) ovl++;
        if (wr_busy && !wr_busy_q) wr_grants.push_back(int'(wr_owner));
        if (rd_busy && !rd_busy_q) rd_grants.push_back(int'(rd_owner));
        wr_busy_q = wr_busy;
        rd_busy_q = rd_busy;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic sel_rdy(input int ch, input int m);
        case (ch)
            0:       return s_awrdy[m];
            1:       return s_wrdy[m];
            2:       return s_bvld[m];
            3:       return s_arrdy[m];
            default: return s_rvld[m];
        endcase
    endfunction

    // Waits (bounded) for the handshake on channel ch of manager m; returns at posedge+1.
    task automatic wait_hs(input int ch, input int m, input string tag,
                           output logic [1:0] resp, output logic [31:0] data);
        int n = 0;
        resp = 2'bxx;
        data = 'x;
        do begin
            @(negedge clk);
            n++;
        end while (!sel_rdy(ch, m) && n < 300);
        if (sel_rdy(ch, m)) begin
            resp = (ch == 2) ? s_bresp[m] : s_rresp[m];
            data = s_rdata[m];
        end else begin
            check_eq({tag, "_timeout"}, 64'd0, 64'd1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic dly(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    // skew > 0: W leads AW by skew cycles; skew < 0: AW leads W.
    task automatic do_write(input int m, input logic [31:0] a, input logic [31:0] d,
                            input int skew, input logic [1:0] exp_resp, input string tag);
        logic [1:0]  r;
        logic [31:0] x;
        fork
            begin
                if (skew > 0) dly(skew);
                aw_a[m] = a;
                aw_v[m] = 1'b1;
                wait_hs(0, m, {tag, "_aw"}, r, x);
                aw_v[m] = 1'b0;
            end
            begin
                if (skew < 0) dly(-skew);
                w_d[m] = d;
                w_v[m] = 1'b1;
                wait_hs(1, m, {tag, "_w"}, r, x);
                w_v[m] = 1'b0;
            end
        join
        b_r[m] = 1'b1;
        wait_hs(2, m, {tag, "_b"}, r, x);
        b_r[m] = 1'b0;
        check_eq({tag, "_bresp"}, 64'(r), 64'(exp_resp));
    endtask

    task automatic do_read(input int m, input logic [31:0] a, input logic [31:0] exp_d,
                           input logic [1:0] exp_resp, input string tag);
        logic [1:0]  r;
        logic [31:0] x;
        ar_a[m] = a;
        ar_v[m] = 1'b1;
        wait_hs(3, m, {tag, "_ar"}, r, x);
        ar_v[m] = 1'b0;
        r_r[m] = 1'b1;
        wait_hs(4, m, {tag, "_r"}, r, x);
        r_r[m] = 1'b0;
        check_eq({tag, "_rresp"}, 64'(r), 64'(exp_resp));
        check_eq({tag, "_rdata"}, 64'(x), 64'(exp_d));
    endtask

    task automatic clr_drv();
        for (int i = 0; i < 2; i++) begin
            aw_v[i] = 1'b0; w_v[i] = 1'b0; b_r[i] = 1'b0; ar_v[i] = 1'b0; r_r[i] = 1'b0;
            aw_a[i] = '0;   w_d[i] = '0;   ar_a[i] = '0;
        end
    endtask

    task automatic apply_reset();
        aresetn = 1'b0;
        clr_drv();
        dly(2);
        aresetn = 1'b1;
        dly(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   base, g0;
        logic seen_b;

        aresetn = 1'b0;
        clr_drv();
        dly(2);
        aresetn = 1'b1;

        // Reset state
        @(negedge clk);
        check_eq("rst_m_valids", {m_if.awvalid, m_if.wvalid, m_if.bready, m_if.arvalid, m_if.rready}, 5'b0);
        check_eq("rst_s0_outs", {s0_if.awready, s0_if.wready, s0_if.bvalid, s0_if.arready, s0_if.rvalid}, 5'b0);
        check_eq("rst_s1_outs", {s1_if.awready, s1_if.wready, s1_if.bvalid, s1_if.arready, s1_if.rvalid}, 5'b0);
        check_eq("rst_busy", {wr_busy, rd_busy}, 2'b00);
        check_eq("rst_owner", {wr_owner, rd_owner}, 2'b11);
        dly(1);

        // Single write from s0, AW and W together; m_axi.awvalid one cycle later
        base = s1_act;
        fork
            do_write(0, 32'h00, 32'hDEADBEEF, 0, 2'b00, "single");
            begin
                @(negedge clk);
                check_eq("single_awv_c0", m_if.awvalid, 1'b0);
                check_eq("single_awrdy_c0", s0_if.awready, 1'b0);
                @(negedge clk);
                check_eq("single_awv_c1", m_if.awvalid, 1'b1);
                check_eq("single_busy_owner", {wr_busy, wr_owner}, 2'b10);
            end
        join
        check_eq("single_awprot", last_awprot, 3'b000);
        do_read(0, 32'h00, 32'hDEADBEEF, 2'b00, "single_rd");
        check_eq("single_s1_quiet", s1_act - base, 0);

        // Contention after reset: s0 first, then s1
        apply_reset();
        g0 = wr_grants.size();
        fork
            do_write(0, 32'h00, 32'h11111111, 0, 2'b00, "cont0");
            do_write(1, 32'h04, 32'h22222222, 0, 2'b00, "cont1");
        join
        check_eq("cont_ngrants", wr_grants.size() - g0, 2);
        if (wr_grants.size() - g0 == 2) begin
            check_eq("cont_grant0", wr_grants[g0], 0);
            check_eq("cont_grant1", wr_grants[g0+1], 1);
        end
        do_read(0, 32'h00, 32'h11111111, 2'b00, "cont_rd0");
        do_read(1, 32'h04, 32'h22222222, 2'b00, "cont_rd1");

        // Fairness: both managers issue 8 back-to-back reads; rd_owner is 1 here
        g0 = rd_grants.size();
        fork
            for (int i = 0; i < 8; i++) do_read(0, 32'h00, 32'h11111111, 2'b00, "fair0");
            for (int i = 0; i < 8; i++) do_read(1, 32'h04, 32'h22222222, 2'b00, "fair1");
        join
        check_eq("fair_ngrants", rd_grants.size() - g0, 16);
        if (rd_grants.size() - g0 == 16)
            for (int i = 0; i < 16; i++)
                check_eq($sformatf("fair_grant%0d", i), rd_grants[g0+i], i % 2);

        // Skewed channels on s1: W leads AW by 3, then AW leads W by 3
        base = m_aw_hs;
        g0   = m_w_hs;
        begin
            int s_aw0, s_w0;
            s_aw0 = s1_aw_hs;
            s_w0  = s1_w_hs;
            do_write(1, 32'h0C, 32'h33333333, 3, 2'b00, "skew_wfirst");
            do_write(1, 32'h10, 32'h44444444, -3, 2'b00, "skew_awfirst");
            check_eq("skew_m_aw_hs", m_aw_hs - base, 2);
            check_eq("skew_m_w_hs", m_w_hs - g0, 2);
            check_eq("skew_s1_aw_hs", s1_aw_hs - s_aw0, 2);
            check_eq("skew_s1_w_hs", s1_w_hs - s_w0, 2);
        end
        check_eq("skew_awprot", last_awprot, 3'b010);
        do_read(0, 32'h0C, 32'h33333333, 2'b00, "skew_rd0");
        do_read(0, 32'h10, 32'h44444444, 2'b00, "skew_rd1");

        // Error response pass-through
        do_write(1, 32'h200, 32'h55555555, 0, 2'b10, "err_wr");
        do_read(0, 32'h200, 32'h0, 2'b10, "err_rd");

        // Concurrency: s0 write alongside s1 read
        base = ovl;
        fork
            do_write(0, 32'h08, 32'hADADABAB, 0, 2'b00, "conc_wr");
            do_read(1, 32'h04, 32'h22222222, 2'b00, "conc_rd");
        join
        check_eq("conc_overlap", (ovl - base) > 0, 1'b1);
        check_eq("conc_owners", {wr_owner, rd_owner}, 2'b01);
        check_eq("conc_arprot", last_arprot, 3'b010);
        do_read(0, 32'h08, 32'hADADABAB, 2'b00, "conc_rdback");

        // Reset during W_FWD after AW handshake, before W
        begin
            logic [1:0]  r;
            logic [31:0] x;
            aw_a[0] = 32'h18;
            aw_v[0] = 1'b1;
            wait_hs(0, 0, "rstmid_aw", r, x);
            aw_v[0] = 1'b0;
            @(negedge clk);
            check_eq("rstmid_pre_busy", wr_busy, 1'b1);
            #1 aresetn = 1'b0;
            #1;
            check_eq("rstmid_m", {m_if.awvalid, m_if.wvalid, m_if.bready, m_if.arvalid, m_if.rready}, 5'b0);
            check_eq("rstmid_s0", {s0_if.awready, s0_if.wready, s0_if.bvalid, s0_if.arready, s0_if.rvalid}, 5'b0);
            check_eq("rstmid_s1", {s1_if.awready, s1_if.wready, s1_if.bvalid, s1_if.arready, s1_if.rvalid}, 5'b0);
            check_eq("rstmid_busy_in", wr_busy, 1'b0);
            clr_drv();
            @(posedge clk);
            #1 aresetn = 1'b1;
            seen_b = 1'b0;
            repeat (3) begin
                @(negedge clk);
                seen_b |= s_bvld[0];
            end
            check_eq("rstmid_busy_owner", {wr_busy, wr_owner, rd_owner}, 3'b011);
            check_eq("rstmid_no_b", seen_b, 1'b0);
        end
        dly(1);
        do_write(0, 32'h14, 32'hCAFEF00D, 0, 2'b00, "post_wr");
        do_read(0, 32'h14, 32'hCAFEF00D, 2'b00, "post_rd");

        dly(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
